dmem_ctrl: RTL and testbench

Data-memory controller between the `mem` stage and a synchronous single-port data SRAM. The `mem` stage assumes a combinational RAM, so this block converts its RAM requests into multi-cycle transactions and raises a stall request to freeze the pipeline until each transaction completes. Every access starts with a read, because the `mem` stage builds sub-word stores (SB/SH) by merging into the read word. A store therefore becomes read → merge (done in `mem`) → write.

---
 rtl/dmem_ctrl_pkg.sv | 14 +
 rtl/dmem_sram.sv | 27 ++
 rtl/dmem_ctrl.sv | 94 +++++++++
 tb/tb_dmem_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared state encoding and sizing for the data-memory controller
package dmem_ctrl_pkg;

  // Transaction phases: every access reads first, stores add a write phase
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_RD   = 2'd1,
    DMEM_WR   = 2'd2,
    DMEM_DONE = 2'd3
  } dmem_state_e;

  localparam int DMEM_DEPTH = 1024;

endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - single-port data SRAM, synchronous read (1-cycle latency) and write
module dmem_sram #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  re_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Storage array is deliberately unreset; read data appears the cycle after re_i
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - turns the mem stage's combinational RAM requests into stalled SRAM transactions
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = DMEM_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ram_ce_i,
  input  logic                  ram_w_request_i,
  input  logic [ADDR_WIDTH-1:0] ram_addr_i,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  stall_req_o,
  output logic                  err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-3:0] DEPTH_LIM = (ADDR_WIDTH-2)'(DEPTH_WORDS);

  dmem_state_e           state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] sram_rdata;
  logic                  sram_re;
  logic                  sram_we;
  logic [IDX_W-1:0]      sram_addr;
  logic                  unused_addr_bits;

  // The read is launched straight from the request so data is ready in RD;
  // the write reuses the latched address since upstream data arrives later.
  // Both enables are gated by reset so a store interrupted by reset never lands.
  assign sram_re   = rst_n_i && (state == DMEM_IDLE) && ram_ce_i;
  assign sram_we   = rst_n_i && (state == DMEM_WR) && !err_q;
  assign sram_addr = (state == DMEM_WR) ? addr_q[IDX_W+1:2] : ram_addr_i[IDX_W+1:2];

  assign unused_addr_bits = ^{ram_addr_i[1:0], addr_q[1:0], addr_q[ADDR_WIDTH-1:IDX_W+2]};

  dmem_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk_i  (clk_i),
    .re_i   (sram_re),
    .we_i   (sram_we),
    .addr_i (sram_addr),
    .wdata_i(ram_data_i),
    .rdata_o(sram_rdata)
  );

  // Transaction FSM plus the request latches and returned read word
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= DMEM_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (ram_ce_i) begin
            addr_q <= ram_addr_i;
            we_q   <= ram_w_request_i;
            err_q  <= (ram_addr_i[ADDR_WIDTH-1:2] >= DEPTH_LIM);
            state  <= DMEM_RD;
          end
        end
        DMEM_RD: begin
          rdata_q <= err_q ? '0 : sram_rdata;
          state   <= we_q ? DMEM_WR : DMEM_DONE;
        end
        DMEM_WR: begin
          state <= DMEM_DONE;
        end
        default: begin
          state <= DMEM_IDLE;
        end
      endcase
    end
  end

  assign ram_data_o  = rdata_q;
  assign stall_req_o = rst_n_i &&
                       (((state == DMEM_IDLE) && ram_ce_i) ||
                        (state == DMEM_RD) || (state == DMEM_WR));
  assign err_o       = (state == DMEM_DONE) && err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl with a mem-stage merge model
module tb_dmem_ctrl;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic          wreq = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          stall;
  logic          err;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .ram_ce_i       (ce),
    .ram_w_request_i(wreq),
    .ram_addr_i     (addr),
    .ram_data_i     (wdata),
    .ram_data_o     (rdata),
    .stall_req_o    (stall),
    .err_o          (err)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          stalls;
    string       name;
  } exp_t;

  exp_t sb [$];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'(i * 32'h0101_0101) ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // One mem-stage access: issue, follow the stall, merge in WR, then score at DONE
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input string name, input bit count);
    exp_t        e;
    exp_t        got;
    int          n;
    int          idx;
    logic        oor;
    logic [31:0] old;
    oor = (a[31:2] >= 30'(DEPTH));
    idx = int'(a[11:2]);
    old = oor ? 32'h0 : model[idx];
    e.rd = exp_rd;
    e.er = exp_err;
    e.stalls = w ? 3 : 2;
    e.name = name;
    sb.push_back(e);
    if (w && !oor) model[idx] = merge(old, wd, be);

    @(posedge clk);
    #1;
    ce = 1'b1;
    wreq = w;
    addr = a;
    wdata = 32'h0;
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      if (!stall) break;
      if (count) chk({name, "_err_busy"}, {31'b0, err}, 32'h0);
      if (count && w && n == 2) chk({name, "_wr_rdata"}, rdata, old);
      wdata = merge(rdata, wd, be);
      n++;
    end
    if (count) chk({name, "_done"}, {31'b0, stall}, 32'h0);
    ce = 1'b0;
    wreq = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb: got empty scoreboard expected entry", name);
    end else begin
      got = sb.pop_front();
      if (count) begin
        chk({got.name, "_stalls"}, 32'(n), 32'(got.stalls));
        chk({got.name, "_rdata"}, rdata, got.rd);
        chk({got.name, "_err"}, {31'b0, err}, {31'b0, got.er});
      end
    end
  endtask

  initial begin
    // reset held with a request pending: everything stays quiet
    rst_n = 1'b0;
    ce = 1'b1;
    addr = 32'h100;
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    ce = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stall", {31'b0, stall}, 32'h0);

    // fill the whole array with a known pattern so later compares are exact
    for (int i = 0; i < DEPTH; i++) begin
      access(1'b1, 32'(i * 4), 4'hF, pat(i), 32'h0, 1'b0, "init", 1'b0);
    end

    tv[0]  = '{1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, pat(64),      1'b0, "sw_100"};
    tv[1]  = '{1'b0, 32'h0000_0100, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0, "lw_100"};
    tv[2]  = '{1'b1, 32'h0000_0200, 4'hF, 32'h1122_3344, pat(128),     1'b0, "sw_200"};
    tv[3]  = '{1'b1, 32'h0000_0201, 4'h2, 32'h0000_AA00, 32'h1122_3344, 1'b0, "sb_201"};
    tv[4]  = '{1'b0, 32'h0000_0200, 4'h0, 32'h0,         32'h1122_AA44, 1'b0, "lw_200"};
    tv[5]  = '{1'b1, 32'h0000_0102, 4'hC, 32'h1234_0000, 32'hDEAD_BEEF, 1'b0, "sh_102"};
    tv[6]  = '{1'b0, 32'h0000_0100, 4'h0, 32'h0,         32'h1234_BEEF, 1'b0, "lw_100b"};
    tv[7]  = '{1'b0, 32'h0000_1000, 4'h0, 32'h0,         32'h0,         1'b1, "lw_oor"};
    tv[8]  = '{1'b1, 32'h0000_1000, 4'hF, 32'h5555_5555, 32'h0,         1'b1, "sw_oor"};
    tv[9]  = '{1'b1, 32'h0000_0040, 4'hF, 32'hCAFE_F00D, pat(16),      1'b0, "sw_40"};
    tv[10] = '{1'b0, 32'h0000_0040, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0, "lw_40"};
    tv[11] = '{1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,         32'h0,         1'b1, "lw_top"};
    tv[12] = '{1'b0, 32'h0000_0FFC, 4'h0, 32'h0,         pat(1023),    1'b0, "lw_last"};

    for (int k = 0; k < 13; k++) begin
      access(tv[k].w, tv[k].a, tv[k].be, tv[k].wd, tv[k].exp_rd, tv[k].exp_err, tv[k].name, 1'b1);
    end

    // err_o must drop again once the out-of-range transaction has finished
    @(negedge clk);
    chk("err_after_done", {31'b0, err}, 32'h0);

    // full-array compare: the dropped out-of-range store touched no word
    for (int i = 0; i < DEPTH; i++) begin
      access(1'b0, 32'(i * 4), 4'h0, 32'h0, model[i], 1'b0, $sformatf("arr_%0d", i), 1'b1);
    end

    // reset asserted during the WR cycle of a store, before its write edge
    @(posedge clk);
    #1;
    ce = 1'b1;
    wreq = 1'b1;
    addr = 32'h80;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    wdata = 32'h7777_7777;
    rst_n = 1'b0;
    #2;
    chk("midrst_stall", {31'b0, stall}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_err", {31'b0, err}, 32'h0);
    ce = 1'b0;
    wreq = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    access(1'b0, 32'h80, 4'h0, 32'h0, pat(32), 1'b0, "lw_after_rst", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
